z80_uart_tx_port: RTL

- Z80 I/O responder in the CPLD: the target end of the CPU I/O cycle.
- CPU `OUT` cycles to the data port push bytes into a small TX FIFO. A serial shifter drains the FIFO as 8N1 frames on `tx`.
- CPU `IN` cycles read a status port and a divisor port over the tristate data bus.
- `io_claim` tells the motherboard to release decoding of the claimed ports.

---
 rtl/z80_uart_tx_port.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/z80_uart_tx_port.sv
// z80_uart_tx_port
// Z80 I/O responder that turns CPU OUT cycles into 8N1 serial frames.
// Writes to DATA_PORT queue bytes in a small FIFO that a shifter drains on tx.
// Writes to DIV_PORT set the baud divisor, where the bit period is (div+1) clk.
// IN cycles to STAT_PORT and DIV_PORT are answered on the tristate bus.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   iorq     Z80 IORQ, active low
//   rd       Z80 RD, active low
//   wr       Z80 WR, active low
//   A        Z80 address bus, low byte
//   D        Z80 data bus (driven only during status/divisor reads)
//   tx       serial output, idle high
//   io_claim high whenever A addresses one of the three ports
module z80_uart_tx_port #(
    parameter logic [7:0] DATA_PORT  = 8'hEF,
    parameter logic [7:0] STAT_PORT  = 8'hEE,
    parameter logic [7:0] DIV_PORT   = 8'hED,
    parameter logic [7:0] DIV_RESET  = 8'd29,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] A,
    inout  wire  [7:0] D,
    output logic       tx,
    output logic       io_claim
);

    localparam logic [2:0] DEPTH_CNT = 3'(FIFO_DEPTH);
    localparam logic [1:0] PTR_MASK  = 2'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic       iorq_s1, iorq_s2, wr_s1, wr_s2, rd_s1, rd_s2;
    logic [7:0] a_s1, a_s2, d_s1, d_s2;
    logic       wstb, wstb_d, rstb, rstb_d;
    logic       wr_event, rd_end;

    logic [7:0] divisor;
    logic       overflow;
    logic [7:0] mem [FIFO_DEPTH];
    logic [1:0] wp, rp;
    logic [2:0] count;
    logic       fifo_full, fifo_empty;
    logic       push_req, push, pop, ovf_set, ovf_clr;

    state_t     state, state_next;
    logic [7:0] shift, div_lat, bit_cnt;
    logic [2:0] bit_idx;
    logic       bit_done;

    logic       sel_stat, sel_div, rd_drive;
    logic [7:0] stat, rd_data;

    // Bus strobes, address and data travel through the same two-flop
    // pipeline so that an event always sees A/D captured alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iorq_s1 <= 1'b1;
            iorq_s2 <= 1'b1;
            wr_s1   <= 1'b1;
            wr_s2   <= 1'b1;
            rd_s1   <= 1'b1;
            rd_s2   <= 1'b1;
            a_s1    <= '0;
            a_s2    <= '0;
            d_s1    <= '0;
            d_s2    <= '0;
            wstb_d  <= 1'b0;
            rstb_d  <= 1'b0;
        end else begin
            iorq_s1 <= iorq;
            iorq_s2 <= iorq_s1;
            wr_s1   <= wr;
            wr_s2   <= wr_s1;
            rd_s1   <= rd;
            rd_s2   <= rd_s1;
            a_s1    <= A;
            a_s2    <= a_s1;
            d_s1    <= D;
            d_s2    <= d_s1;
            wstb_d  <= wstb;
            rstb_d  <= rstb;
        end
    end

    assign wstb     = ~iorq_s2 & ~wr_s2;
    assign rstb     = ~iorq_s2 & ~rd_s2;
    assign wr_event = wstb & ~wstb_d;
    assign rd_end   = rstb_d & ~rstb;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == 3'd0);

    // A push into a full FIFO still fits when the shifter pops on the same clk.
    assign push_req = wr_event & (a_s2 == DATA_PORT);
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;
    assign ovf_clr  = rd_end & (a_s2 == STAT_PORT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            if (wr_event && (a_s2 == DIV_PORT))
                divisor <= d_s2;
            // A fresh overflow beats a clearing status read on the same clk.
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (push)
                wp <= (wp + 2'd1) & PTR_MASK;
            if (pop)
                rp <= (rp + 2'd1) & PTR_MASK;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= d_s2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign bit_done = (bit_cnt == 8'd0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx         = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_done)
                    state_next = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (bit_done && (bit_idx == 3'd7))
                    state_next = STOP;
            end
            STOP: begin
                // Chain straight into the next frame so there is no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The divisor is captured once per frame so a mid-frame divisor write
    // only affects the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift   <= '0;
            div_lat <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (pop) begin
            shift   <= mem[rp];
            div_lat <= divisor;
            bit_cnt <= divisor;
            bit_idx <= '0;
        end else if (state != IDLE) begin
            if (bit_done) begin
                bit_cnt <= div_lat;
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_cnt <= bit_cnt - 8'd1;
            end
        end
    end

    assign sel_stat = (A == STAT_PORT);
    assign sel_div  = (A == DIV_PORT);
    assign stat     = {1'b0, count, overflow, (state != IDLE), fifo_full, fifo_empty};
    assign rd_data  = sel_stat ? stat : divisor;
    assign rd_drive = reset & ~iorq & ~rd & (sel_stat | sel_div);
    assign D        = rd_drive ? rd_data : 8'bz;

    assign io_claim = (A == DATA_PORT) | (A == STAT_PORT) | (A == DIV_PORT);

endmodule
